// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the CPU
// load/store port and a DMA/loader port. One request is latched at a time,
// issued to the memory for one cycle, and then held until the read latency
// or the write stall has elapsed.
module data_mem_arbiter #(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned DMA_MAX_WAIT = 8,
  parameter logic [3:0]  DMA_MASK     = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_clk_stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] READ_LAT_C  = 3'(READ_LAT);
  localparam logic [7:0] MAX_WAIT_C  = 8'(DMA_MAX_WAIT);
  localparam logic [3:0] WR_TMO_LAST = 4'd15;

  state_e      state_q, state_d;
  logic        own_dma_q, own_dma_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  tmo_q, tmo_d;
  logic [7:0]  starve_q, starve_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        gnt_c;
  logic        cpu_req;
  logic        dma_win;
  logic        busy;

  assign cpu_req = cpu_memread | cpu_memwrite;
  // DMA takes the slot when it has starved long enough or the CPU is quiet.
  assign dma_win = dma_req & ((starve_q == MAX_WAIT_C) | ~cpu_req);

  // State and latched-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_dma_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      wait_cnt_q  <= '0;
      tmo_q       <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_dma_q   <= own_dma_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      wait_cnt_q  <= wait_cnt_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Next-state logic: arbitration in IDLE, latency/stall tracking in WAIT.
  always_comb begin
    state_d     = state_q;
    own_dma_d   = own_dma_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    wait_cnt_d  = wait_cnt_q;
    tmo_d       = tmo_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    gnt_c       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dma_win) begin
          own_dma_d = 1'b1;
          wr_d      = dma_we;
          addr_d    = dma_addr;
          wdata_d   = dma_wdata;
          mask_d    = DMA_MASK;
          gnt_c     = 1'b1;
          state_d   = S_ISSUE;
        end else if (cpu_req) begin
          own_dma_d = 1'b0;
          // A store wins over a load if both are raised together.
          wr_d      = cpu_memwrite;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          mask_d    = cpu_sign_mask;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = READ_LAT_C;
        tmo_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (!wr_q) begin
          // Read data is valid in the last WAIT cycle.
          if (wait_cnt_q <= 3'd1) begin
            wait_cnt_d = '0;
            state_d    = S_DONE;
            if (own_dma_q) dma_rdata_d = mem_rdata;
            else           cpu_rdata_d = mem_rdata;
          end else begin
            wait_cnt_d = wait_cnt_q - 3'd1;
          end
        end else begin
          // Writes finish when the memory drops its stall, or after the guard.
          if (!mem_clk_stall || (tmo_q == WR_TMO_LAST)) begin
            state_d = S_DONE;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Starvation counter: counts denied DMA request cycles, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!dma_req || gnt_c) begin
      starve_d = '0;
    end else if (starve_q != MAX_WAIT_C) begin
      starve_d = starve_q + 8'd1;
    end
  end

  assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);

  // Memory command only in ISSUE; address/data/mask held through WAIT.
  assign mem_addr      = busy ? addr_q  : '0;
  assign mem_wdata     = busy ? wdata_q : '0;
  assign mem_sign_mask = busy ? mask_q  : '0;
  assign mem_memread   = (state_q == S_ISSUE) & ~wr_q;
  assign mem_memwrite  = (state_q == S_ISSUE) &  wr_q;

  // Grant is suppressed while reset is held so a grant is never lost.
  assign dma_gnt    = gnt_c & ~rst;
  assign dma_rvalid = (state_q == S_DONE) & own_dma_q & ~wr_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_stall  = cpu_req & ~((state_q == S_DONE) & ~own_dma_q);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a one-cycle-latency memory model.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_memread = 1'b0;
  logic        cpu_memwrite = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_sign_mask = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata = '0;
  logic        mem_clk_stall = 1'b0;

  logic [31:0] rd_val = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  data_mem_arbiter #(
    .READ_LAT     (1),
    .DMA_MAX_WAIT (4),
    .DMA_MASK     (4'b0111)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_memread   (cpu_memread),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_sign_mask (cpu_sign_mask),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .dma_req       (dma_req),
    .dma_we        (dma_we),
    .dma_addr      (dma_addr),
    .dma_wdata     (dma_wdata),
    .dma_gnt       (dma_gnt),
    .dma_rvalid    (dma_rvalid),
    .dma_rdata     (dma_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_memread   (mem_memread),
    .mem_memwrite  (mem_memwrite),
    .mem_sign_mask (mem_sign_mask),
    .mem_rdata     (mem_rdata),
    .mem_clk_stall (mem_clk_stall)
  );

  always #5 clk = ~clk;

  // Memory model: data valid for one cycle, one cycle after the read command.
  always @(posedge clk) begin
    if (mem_memread) mem_rdata <= rd_val;
    else             mem_rdata <= 32'hBAD0BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       own [6];
    logic       own_exp [6];
    int         n_iss;
    int         cyc;

    own_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state.
    #3;
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_mem_read", {31'h0, mem_memread}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_dma_gnt", {31'h0, dma_gnt}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // CPU load from 0x10.
    cpu_memread = 1'b1; cpu_addr = 32'h10; cpu_sign_mask = 4'b0010; rd_val = 32'hDEADBEEF;
    #1;
    check("rd_idle_stall", {31'h0, cpu_stall}, 32'h1);
    check("rd_idle_memread", {31'h0, mem_memread}, 32'h0);
    tick();
    check("rd_issue_memread", {31'h0, mem_memread}, 32'h1);
    check("rd_issue_addr", mem_addr, 32'h10);
    check("rd_issue_mask", {28'h0, mem_sign_mask}, 32'h2);
    check("rd_issue_stall", {31'h0, cpu_stall}, 32'h1);
    tick();
    check("rd_wait_memread", {31'h0, mem_memread}, 32'h0);
    check("rd_wait_stall", {31'h0, cpu_stall}, 32'h1);
    tick();
    check("rd_done_stall", {31'h0, cpu_stall}, 32'h0);
    check("rd_done_data", cpu_rdata, 32'hDEADBEEF);
    cpu_memread = 1'b0;
    tick();
    check("rd_hold_data", cpu_rdata, 32'hDEADBEEF);
    check("rd_idle_addr", mem_addr, 32'h0);

    // CPU store to 0x20 with one stalled WAIT cycle.
    cpu_memwrite = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678; cpu_sign_mask = 4'b0111;
    #1;
    check("wr_idle_memwrite", {31'h0, mem_memwrite}, 32'h0);
    tick();
    check("wr_issue_memwrite", {31'h0, mem_memwrite}, 32'h1);
    check("wr_issue_memread", {31'h0, mem_memread}, 32'h0);
    check("wr_issue_addr", mem_addr, 32'h20);
    check("wr_issue_wdata", mem_wdata, 32'h12345678);
    check("wr_issue_mask", {28'h0, mem_sign_mask}, 32'h7);
    mem_clk_stall = 1'b1;
    tick();
    check("wr_wait1_memwrite", {31'h0, mem_memwrite}, 32'h0);
    check("wr_wait1_stall", {31'h0, cpu_stall}, 32'h1);
    tick();
    mem_clk_stall = 1'b0;
    check("wr_wait2_stall", {31'h0, cpu_stall}, 32'h1);
    tick();
    check("wr_done_stall", {31'h0, cpu_stall}, 32'h0);
    check("wr_keeps_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_memwrite = 1'b0;
    tick();

    // DMA read from 0x40.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; rd_val = 32'hCAFEF00D;
    #1;
    check("dmard_gnt", {31'h0, dma_gnt}, 32'h1);
    tick();
    dma_req = 1'b0;
    check("dmard_gnt_pulse", {31'h0, dma_gnt}, 32'h0);
    check("dmard_issue_read", {31'h0, mem_memread}, 32'h1);
    check("dmard_issue_addr", mem_addr, 32'h40);
    check("dmard_issue_mask", {28'h0, mem_sign_mask}, 32'h7);
    tick();
    check("dmard_wait_rvalid", {31'h0, dma_rvalid}, 32'h0);
    tick();
    check("dmard_done_rvalid", {31'h0, dma_rvalid}, 32'h1);
    check("dmard_done_data", dma_rdata, 32'hCAFEF00D);
    check("dmard_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    check("dmard_rvalid_pulse", {31'h0, dma_rvalid}, 32'h0);
    check("dmard_hold_data", dma_rdata, 32'hCAFEF00D);

    // DMA write to 0x44: no read-valid pulse.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h44; dma_wdata = 32'hA5A5A5A5;
    #1;
    check("dmawr_gnt", {31'h0, dma_gnt}, 32'h1);
    tick();
    dma_req = 1'b0;
    check("dmawr_issue_write", {31'h0, mem_memwrite}, 32'h1);
    check("dmawr_issue_wdata", mem_wdata, 32'hA5A5A5A5);
    check("dmawr_issue_mask", {28'h0, mem_sign_mask}, 32'h7);
    tick();
    tick();
    check("dmawr_done_rvalid", {31'h0, dma_rvalid}, 32'h0);
    tick();

    // CPU load and store together: only the store is issued.
    cpu_memread = 1'b1; cpu_memwrite = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55AA55AA;
    tick();
    check("both_issue_write", {31'h0, mem_memwrite}, 32'h1);
    check("both_issue_read", {31'h0, mem_memread}, 32'h0);
    check("both_issue_wdata", mem_wdata, 32'h55AA55AA);
    tick();
    tick();
    check("both_done_stall", {31'h0, cpu_stall}, 32'h0);
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    tick();

    // Write timeout guard: stall never clears, access ends after 16 WAIT cycles.
    cpu_memwrite = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'h0; mem_clk_stall = 1'b1;
    #1;
    cyc = 0;
    while (cpu_stall && cyc < 40) begin
      tick();
      cyc++;
    end
    check("wr_timeout_cycles", 32'(cyc), 32'd18);
    cpu_memwrite = 1'b0; mem_clk_stall = 1'b0;
    tick();

    // CPU and DMA both requesting continuously: owners alternate.
    cpu_memread = 1'b1; cpu_addr = 32'h100; rd_val = 32'h11111111;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
    #1;
    n_iss = 0;
    for (int i = 0; i < 24; i++) begin
      if (mem_memread) begin
        if (n_iss < 6) own[n_iss] = (mem_addr == 32'h200);
        n_iss++;
      end
      tick();
    end
    cpu_memread = 1'b0; dma_req = 1'b0;
    check("arb_issue_count", 32'(n_iss), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("arb_owner%0d", i), {31'h0, own[i]}, {31'h0, own_exp[i]});
    end
    tick();
    tick();

    // Reset in WAIT of a CPU load, then restart of the held request.
    cpu_memread = 1'b1; cpu_addr = 32'h50; rd_val = 32'h13579BDF;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_cpu_rdata", cpu_rdata, 32'h0);
    check("arst_dma_rdata", dma_rdata, 32'h0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_read", {31'h0, mem_memread}, 32'h0);
    check("arst_cpu_stall", {31'h0, cpu_stall}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("arst_idle_read", {31'h0, mem_memread}, 32'h0);
    tick();
    check("arst_issue_read", {31'h0, mem_memread}, 32'h1);
    check("arst_issue_addr", mem_addr, 32'h50);
    tick();
    tick();
    check("arst_done_stall", {31'h0, cpu_stall}, 32'h0);
    check("arst_done_data", cpu_rdata, 32'h13579BDF);
    cpu_memread = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
